// File: rtl/rv_retire_trace_buffer.sv
// Retire-stage trace observer: classifies up to NRET retires per cycle, buffers them
// in a circular FIFO drained over valid/ready, and keeps per-class and drop counters.
module rv_retire_trace_buffer #(
    parameter int NRET   = 2,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 32,
    parameter int NCLASS = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    clear_i,
    input  logic [NRET-1:0]         ret_valid_i,
    input  logic [NRET*32-1:0]      ret_pc_i,
    input  logic [NRET*32-1:0]      ret_insn_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [31:0]             out_pc_o,
    output logic [31:0]             out_insn_o,
    output logic [3:0]              out_class_o,
    output logic                    out_compressed_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    overflow_o,
    output logic [CNT_W-1:0]        drop_cnt_o,
    output logic [NCLASS*CNT_W-1:0] class_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [3:0] CL_ALU    = 4'd0;
    localparam logic [3:0] CL_MULDIV = 4'd1;
    localparam logic [3:0] CL_BRANCH = 4'd2;
    localparam logic [3:0] CL_JUMP   = 4'd3;
    localparam logic [3:0] CL_LOAD   = 4'd4;
    localparam logic [3:0] CL_STORE  = 4'd5;
    localparam logic [3:0] CL_SYSTEM = 4'd6;
    localparam logic [3:0] CL_FP     = 4'd7;
    localparam logic [3:0] CL_AMO    = 4'd8;
    localparam logic [3:0] CL_OTHER  = 4'd9;

    function automatic logic [3:0] f_classify(input logic [31:0] insn);
        logic [3:0] cls;
        cls = CL_OTHER;
        if (insn[1:0] != 2'b11) begin
            case (insn[1:0])
                2'b00: begin
                    case (insn[15:13])
                        3'b010, 3'b011: cls = CL_LOAD;
                        3'b110, 3'b111: cls = CL_STORE;
                        default:        cls = (insn[15:0] == 16'h0) ? CL_OTHER : CL_ALU;
                    endcase
                end
                2'b01: begin
                    case (insn[15:13])
                        3'b001, 3'b101: cls = CL_JUMP;
                        3'b110, 3'b111: cls = CL_BRANCH;
                        default:        cls = CL_ALU;
                    endcase
                end
                default: begin
                    case (insn[15:13])
                        3'b010, 3'b011: cls = CL_LOAD;
                        3'b110, 3'b111: cls = CL_STORE;
                        3'b100: begin
                            // C.JR / C.JALR / C.EBREAK share funct3 and need rs2 = 0
                            if (insn[6:2] != 5'd0)      cls = CL_ALU;
                            else if (!insn[12])         cls = CL_JUMP;
                            else if (insn[11:7] == 5'd0) cls = CL_SYSTEM;
                            else                        cls = CL_JUMP;
                        end
                        default: cls = CL_ALU;
                    endcase
                end
            endcase
        end else begin
            case (insn[6:0])
                7'b0110111, 7'b0010111, 7'b0010011: cls = CL_ALU;
                7'b0110011: cls = (insn[31:25] == 7'b0000001) ? CL_MULDIV : CL_ALU;
                7'b1100011: cls = CL_BRANCH;
                7'b1101111, 7'b1100111: cls = CL_JUMP;
                7'b0000011, 7'b0000111: cls = CL_LOAD;
                7'b0100011, 7'b0100111: cls = CL_STORE;
                7'b1110011, 7'b0001111: cls = CL_SYSTEM;
                7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111, 7'b1010011: cls = CL_FP;
                7'b0101111: cls = (insn[14:12] == 3'b010) ? CL_AMO : CL_OTHER;
                default:    cls = CL_OTHER;
            endcase
        end
        return cls;
    endfunction

    logic [31:0]      r_pc   [DEPTH];
    logic [31:0]      r_insn [DEPTH];
    logic [3:0]       r_cls  [DEPTH];
    logic             r_cmp  [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_cnt  [NCLASS];

    logic             w_pop;
    logic [LW-1:0]    w_free;
    logic [LW-1:0]    w_cnt;
    logic [LW-1:0]    w_nstore;
    logic [LW-1:0]    w_ndrop;
    logic [NRET-1:0]  w_lane_v;
    logic [NRET-1:0]  w_lane_st;
    logic [LW-1:0]    w_lane_off [NRET];
    logic [3:0]       w_lane_cls [NRET];
    logic [31:0]      w_lane_insn [NRET];
    logic [LW-1:0]    w_cls_inc  [NCLASS];
    logic [CNT_W:0]   w_drop_sum;

    assign out_valid_o = (r_level != '0);
    assign w_pop       = out_valid_o & out_ready_i;
    assign w_free      = LW'(DEPTH) - r_level + LW'(w_pop);

    // Valid lanes take consecutive slots; once space runs out every later lane drops.
    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < NRET; k++) begin
            w_lane_v[k]    = en_i & ret_valid_i[k];
            w_lane_cls[k]  = f_classify(ret_insn_i[32*k +: 32]);
            w_lane_insn[k] = (ret_insn_i[32*k +: 2] != 2'b11) ?
                             {16'h0, ret_insn_i[32*k +: 16]} : ret_insn_i[32*k +: 32];
            w_lane_off[k]  = w_cnt;
            w_lane_st[k]   = w_lane_v[k] && (w_cnt < w_free);
            if (w_lane_v[k]) w_cnt = w_cnt + LW'(1);
        end
        w_nstore   = (w_cnt < w_free) ? w_cnt : w_free;
        w_ndrop    = w_cnt - w_nstore;
        w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_ndrop);
        for (int c = 0; c < NCLASS; c++) begin
            w_cls_inc[c] = '0;
            for (int k = 0; k < NRET; k++) begin
                if (w_lane_v[k] && (w_lane_cls[k] == 4'(c))) w_cls_inc[c] = w_cls_inc[c] + LW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            for (int c = 0; c < NCLASS; c++) r_cnt[c] <= '0;
        end else begin
            for (int k = 0; k < NRET; k++) begin
                if (w_lane_st[k]) begin
                    r_pc  [r_wr_ptr + w_lane_off[k][AW-1:0]] <= ret_pc_i[32*k +: 32];
                    r_insn[r_wr_ptr + w_lane_off[k][AW-1:0]] <= w_lane_insn[k];
                    r_cls [r_wr_ptr + w_lane_off[k][AW-1:0]] <= w_lane_cls[k];
                    r_cmp [r_wr_ptr + w_lane_off[k][AW-1:0]] <= (ret_insn_i[32*k +: 2] != 2'b11);
                end
            end
            r_wr_ptr <= r_wr_ptr + w_nstore[AW-1:0];
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + w_nstore - LW'(w_pop);
            if (w_ndrop != '0) r_overflow <= 1'b1;
            r_drop_cnt <= w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
            for (int c = 0; c < NCLASS; c++) r_cnt[c] <= r_cnt[c] + CNT_W'(w_cls_inc[c]);
        end
    end

    assign out_pc_o         = out_valid_o ? r_pc[r_rd_ptr]   : '0;
    assign out_insn_o       = out_valid_o ? r_insn[r_rd_ptr] : '0;
    assign out_class_o      = out_valid_o ? r_cls[r_rd_ptr]  : '0;
    assign out_compressed_o = out_valid_o ? r_cmp[r_rd_ptr]  : 1'b0;
    assign level_o          = r_level;
    assign overflow_o       = r_overflow;
    assign drop_cnt_o       = r_drop_cnt;

    for (genvar c = 0; c < NCLASS; c++) begin : g_cnt
        assign class_cnt_o[c*CNT_W +: CNT_W] = r_cnt[c];
    end
endmodule

// File: tb/tb_rv_retire_trace_buffer.sv
// Directed bench for rv_retire_trace_buffer: stimulus pushes expected entries to a
// scoreboard queue, a negedge monitor checks every popped entry against it.
module tb_rv_retire_trace_buffer;
    localparam int NRET = 2, DEPTH = 16, CNT_W = 32, NCLASS = 10;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, clr, out_ready;
    logic [1:0]  rv;
    logic [63:0] rpc, rinsn;
    logic        out_valid, out_cmp, overflow;
    logic [31:0] out_pc, out_insn, drop_cnt;
    logic [3:0]  out_cls;
    logic [4:0]  level;
    logic [NCLASS*CNT_W-1:0] class_cnt;

    rv_retire_trace_buffer #(.NRET(NRET), .DEPTH(DEPTH), .CNT_W(CNT_W), .NCLASS(NCLASS)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_i(clr),
        .ret_valid_i(rv), .ret_pc_i(rpc), .ret_insn_i(rinsn),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc),
        .out_insn_o(out_insn), .out_class_o(out_cls), .out_compressed_o(out_cmp),
        .level_o(level), .overflow_o(overflow), .drop_cnt_o(drop_cnt), .class_cnt_o(class_cnt)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [3:0]  cls;
        logic        cmp;
    } ent_t;

    ent_t        sb[$];
    ent_t        mon_e;
    int          n_vec = 0, n_err = 0;
    logic [31:0] m_cnt [NCLASS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] insn, input logic [3:0] cls);
        ent_t e;
        e.pc   = pc;
        e.cmp  = (insn[1:0] != 2'b11);
        e.insn = e.cmp ? {16'h0, insn[15:0]} : insn;
        e.cls  = cls;
        return e;
    endfunction

    // Drive one retire cycle; keep marks lanes expected to land in the buffer.
    task automatic ret(input logic [1:0] v,
                       input logic [31:0] pc0, input logic [31:0] i0, input logic [3:0] c0,
                       input logic [31:0] pc1, input logic [31:0] i1, input logic [3:0] c1,
                       input logic [1:0] keep);
        rv = v; rpc = {pc1, pc0}; rinsn = {i1, i0};
        if (en) begin
            if (v[0]) begin m_cnt[c0]++; if (keep[0]) sb.push_back(mk(pc0, i0, c0)); end
            if (v[1]) begin m_cnt[c1]++; if (keep[1]) sb.push_back(mk(pc1, i1, c1)); end
        end
        @(posedge clk); #1;
        rv = 2'b00;
    endtask

    task automatic chk_cnts(input string tag);
        for (int c = 0; c < NCLASS; c++)
            chk($sformatf("%s_class_cnt%0d", tag, c), class_cnt[c*CNT_W +: CNT_W], m_cnt[c]);
    endtask

    task automatic model_clear();
        sb.delete();
        for (int c = 0; c < NCLASS; c++) m_cnt[c] = '0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 100 && level != 0; i++) begin @(posedge clk); #1; end
        n_vec++;
        if (level != 0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: level %0d queue %0d expected 0 and 0", tag, level, sb.size());
        end
        out_ready = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && !clr && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL pop_unexpected: got pc 0x%08h expected no entry", out_pc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pop_pc",   out_pc,          mon_e.pc);
                    chk("pop_insn", out_insn,        mon_e.insn);
                    chk("pop_cls",  32'(out_cls),    32'(mon_e.cls));
                    chk("pop_cmp",  32'(out_cmp),    32'(mon_e.cmp));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; out_ready = 1'b0;
        rv = '0; rpc = '0; rinsn = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        chk("rst_drop",  drop_cnt, 32'd0);
        chk_cnts("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single addi
        ret(2'b01, 32'h100, 32'h02A00093, 4'd0, 32'h0, 32'h0, 4'd0, 2'b01);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_cls",   32'(out_cls), 32'd0);
        chk("t1_cmp",   32'(out_cmp), 32'd0);
        chk("t1_level", 32'(level), 32'd1);
        chk("t1_cnt0",  class_cnt[0 +: 32], 32'd1);
        drain("t1");

        // capture disabled
        en = 1'b0;
        ret(2'b11, 32'h150, 32'h02A00093, 4'd0, 32'h154, 32'h00000013, 4'd0, 2'b00);
        chk("en_level", 32'(level), 32'd0);
        en = 1'b1;

        // two lanes, compressed head, lane order preserved
        out_ready = 1'b1;
        ret(2'b11, 32'h200, 32'h00004108, 4'd4, 32'h202, 32'h00B50463, 4'd2, 2'b11);
        ret(2'b11, 32'h210, 32'h00000053, 4'd7, 32'h214, 32'h0005B2AF, 4'd9, 2'b11);
        ret(2'b11, 32'h218, 32'h00008082, 4'd3, 32'h21A, 32'h00000505, 4'd0, 2'b11);
        drain("t2");
        chk_cnts("t2");

        // overflow with consumer stalled: 17 retires into 16 slots
        for (int i = 0; i < 8; i++)
            ret(2'b11, 32'h1000 + 32'(8*i), 32'h00000013, 4'd0,
                       32'h1004 + 32'(8*i), 32'h0000A083, 4'd4, 2'b11);
        ret(2'b01, 32'h1040, 32'h0010A023, 4'd5, 32'h0, 32'h0, 4'd0, 2'b00);
        chk("ovf_level", 32'(level), 32'd16);
        chk("ovf_drop",  drop_cnt, 32'd1);
        chk("ovf_flag",  32'(overflow), 32'd1);
        chk("ovf_head",  out_pc, 32'h1000);
        chk_cnts("ovf");
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_hold_pc",   out_pc, 32'h1000);
        chk("ovf_hold_insn", out_insn, 32'h00000013);

        // full with same-cycle pop: one slot frees, lane 1 drops
        out_ready = 1'b1;
        ret(2'b11, 32'h2000, 32'h008000EF, 4'd3, 32'h2004, 32'h0000A001, 4'd3, 2'b01);
        out_ready = 1'b0;
        chk("full_level", 32'(level), 32'd16);
        chk("full_drop",  drop_cnt, 32'd2);
        drain("full");
        chk_cnts("full");

        // mul / c.ebreak / amoadd.w then clear (clear beats a same-cycle retire)
        ret(2'b11, 32'h400, 32'h02B50533, 4'd1, 32'h404, 32'h00009002, 4'd6, 2'b11);
        ret(2'b01, 32'h406, 32'h0005A2AF, 4'd8, 32'h0, 32'h0, 4'd0, 2'b01);
        chk("clr_pre_level", 32'(level), 32'd3);
        chk("clr_pre_head",  32'(out_cls), 32'd1);
        chk_cnts("clr_pre");
        clr = 1'b1; rv = 2'b01; rpc = {32'h0, 32'h500}; rinsn = {32'h0, 32'h00000013};
        @(posedge clk); #1;
        clr = 1'b0; rv = 2'b00;
        model_clear();
        chk("clr_level", 32'(level), 32'd0);
        chk("clr_valid", 32'(out_valid), 32'd0);
        chk("clr_ovf",   32'(overflow), 32'd0);
        chk("clr_drop",  drop_cnt, 32'd0);
        chk_cnts("clr");

        // reset with 5 entries buffered
        ret(2'b11, 32'h600, 32'h00000013, 4'd0, 32'h604, 32'h00000013, 4'd0, 2'b11);
        ret(2'b11, 32'h608, 32'h00000013, 4'd0, 32'h60C, 32'h00000013, 4'd0, 2'b11);
        ret(2'b01, 32'h610, 32'h00000013, 4'd0, 32'h0, 32'h0, 4'd0, 2'b01);
        chk("mr_level", 32'(level), 32'd5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_level0", 32'(level), 32'd0);
        rst_n = 1'b1;
        model_clear();
        ret(2'b01, 32'h300, 32'h008000EF, 4'd3, 32'h0, 32'h0, 4'd0, 2'b01);
        chk("mr_new_level", 32'(level), 32'd1);
        chk("mr_new_cls",   32'(out_cls), 32'd3);
        chk_cnts("mr");
        drain("mr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
